// File: rtl/ram_sp_clr_pkg.sv
// ram_pkg: shared definitions for the ram_sp_clr memory block.
//   state_e      - clear-engine FSM states (S_CLEAR is the reset state)
//   RD_LATENCY   - read latency in cycles, request edge to valid dout
// Optional macro RAM_OUT_REG_EN selects the two-stage output register.
package ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

`ifdef RAM_OUT_REG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/ram_sp_clr_ctrl.sv
// ram_clr_ctrl: clear-engine controller for ram_sp_clr.
// Sweeps every address once after reset and after each clr pulse, driving
// a write strobe and address that the top level muxes into the RAM.
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset (restarts the sweep)
//   clr_i         single-cycle request to start (or restart) a sweep
//   busy_o        high while the sweep runs; user requests are dropped
//   sweep_we_o    write strobe for the sweep write this cycle
//   sweep_addr_o  address written by the sweep this cycle
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  sweep_we_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One spare bit keeps DEPTH-1 distinct from any wrapped value.
  localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic   [ADDR_WIDTH:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_CLEAR: begin
        // A clr mid-sweep restarts from 0 so a full pass always completes.
        if (clr_i) begin
          ptr_d = '0;
        end else if (ptr_q == PTR_LAST) begin
          state_d = S_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      S_READY: begin
        if (clr_i) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy_o       = (state_q == S_CLEAR);
  // No sweep write while reset is held: the first write lands on the edge
  // after reset is released.
  assign sweep_we_o   = (state_q == S_CLEAR) && !rst_i;
  assign sweep_addr_o = ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port synchronous RAM with registered read data, a
// valid flag and a built-in clear engine that fills every word with
// CLEAR_VALUE after reset and on each clr pulse.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   en          access request (one cycle)
//   we          1 = write, 0 = read (sampled with en)
//   addr        word address
//   din         write data
//   clr         pulse that starts a clear sweep
//   dout        registered read data
//   dout_valid  one-cycle pulse per completed read
//   busy        clear sweep running; requests ignored
// Build option: define RAM_OUT_REG_EN for a second output register stage
// (read latency 2 instead of 1).
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;

  logic                  accept;
  logic                  user_we;
  logic                  user_re;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] dout_p1_q;
  logic                  vld_p1_q;

  ram_clr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .busy_o       (busy),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );

  // clr beats a same-cycle request; anything during the sweep is dropped.
  assign accept  = !busy && !clr && !rst;
  assign user_we = accept && en && we;
  assign user_re = accept && en && !we;

  // Sweep and user writes never coincide: user writes need !busy.
  assign wr_en   = sweep_we || user_we;
  assign wr_addr = sweep_we ? sweep_addr : addr;
  assign wr_data = sweep_we ? CLEAR_VALUE : din;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // ---- stage p1: registered read data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= user_re;
      if (user_re) begin
        dout_p1_q <= mem_q[addr];
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_p2_q;
  logic                  vld_p2_q;

  // ---- stage p2: optional output register ----
  // A result already in p1 still drains through p2 after a clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        dout_p2_q <= dout_p1_q;
      end
    end
  end

  assign dout       = dout_p2_q;
  assign dout_valid = vld_p2_q;
`else
  assign dout       = dout_p1_q;
  assign dout_valid = vld_p1_q;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed self-checking bench for ram_sp_clr: default 8x16 instance plus
// a 16-bit x 64-word instance with a non-zero clear value.
module tb_ram_sp_clr;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  int checks   = 0;
  int failures = 0;

  logic       clk = 1'b0;
  logic       rst, en, we, clr;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, busy;

  logic        rst2, en2, we2, clr2;
  logic [5:0]  addr2;
  logic [15:0] din2;
  logic [15:0] dout2;
  logic        dout_valid2, busy2;

  always #5 clk = ~clk;

  ram_sp_clr dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .we         (we),
    .addr       (addr),
    .din        (din),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  ram_sp_clr #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (6),
    .CLEAR_VALUE (16'hA5A5)
  ) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .en         (en2),
    .we         (we2),
    .addr       (addr2),
    .din        (din2),
    .clr        (clr2),
    .dout       (dout2),
    .dout_valid (dout_valid2),
    .busy       (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] a, output logic [7:0] d, output logic v);
    en = 1'b1; we = 1'b0; addr = a;
    tick();
    en = 1'b0;
    for (int i = 1; i < LAT; i++) tick();
    d = dout; v = dout_valid;
  endtask

  // Counts cycles with busy high; records any dout_valid seen meanwhile.
  task automatic wait_sweep1(output int cnt, output logic saw);
    cnt = 0; saw = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin
      if (dout_valid !== 1'b0) saw = 1'b1;
      cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt; logic saw; logic [7:0] d; logic v;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b1 || dout !== 8'h00 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values busy=%b dout=%h vld=%b required busy=1 dout=00 vld=0", busy, dout, dout_valid);
    end
    rst = 1'b0;
    wait_sweep1(cnt, saw);
    checks++;
    if (cnt != 16 || saw !== 1'b0) begin
      failures++;
      $display("FAIL reset_sweep busy_cycles=%0d saw_vld=%b required 16 and 0", cnt, saw);
    end
    for (int i = 0; i < 16; i++) begin
      rd1(4'(i), d, v);
      checks++;
      if (d !== 8'h00 || v !== 1'b1) begin
        failures++;
        $display("FAIL reset_read addr=%0d dout=%h vld=%b required 00 1", i, d, v);
      end
    end
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < 16; i++) wr1(4'(i), 8'(i));
    // Result of request c appears at sample point c+LAT.
    for (int c = 0; c <= 16 + LAT; c++) begin
      if (c >= LAT && c < 16 + LAT) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'(c - LAT)) begin
          failures++;
          $display("FAIL b2b_read idx=%0d dout=%h vld=%b required %h 1", c - LAT, dout, dout_valid, 8'(c - LAT));
        end
      end else begin
        checks++;
        if (dout_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle cycle=%0d vld=%b required 0", c, dout_valid);
        end
      end
      if (c < 16) begin
        en = 1'b1; we = 1'b0; addr = 4'(c);
      end else begin
        en = 1'b0;
      end
      if (c < 16 + LAT) tick();
    end
    en = 1'b0;
  endtask

  task automatic test_busy_drop();
    int cnt; logic saw; logic [7:0] d; logic v;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0; saw = 1'b0;
    // Write issued late in the sweep, after address 3 was already cleared.
    while (busy === 1'b1 && cnt < 200) begin
      if (cnt == 10) begin
        en = 1'b1; we = 1'b1; addr = 4'd3; din = 8'hAA;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      if (dout_valid !== 1'b0) saw = 1'b1;
      cnt++;
      tick();
    end
    en = 1'b0; we = 1'b0;
    checks++;
    if (cnt != 16 || saw !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_sweep busy_cycles=%0d saw_vld=%b required 16 and 0", cnt, saw);
    end
    rd1(4'd3, d, v);
    checks++;
    if (d !== 8'h00 || v !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop_read dout=%h vld=%b required 00 1", d, v);
    end
  endtask

  task automatic test_clr_collision();
    int cnt; logic saw; logic [7:0] d; logic v;
    for (int i = 0; i < 16; i++) wr1(4'(i), 8'h55);
    rd1(4'd5, d, v);
    checks++;
    if (d !== 8'h55 || v !== 1'b1) begin
      failures++;
      $display("FAIL collide_fill dout=%h vld=%b required 55 1", d, v);
    end
    clr = 1'b1; en = 1'b1; we = 1'b0; addr = 4'd5;
    tick();
    clr = 1'b0; en = 1'b0;
    wait_sweep1(cnt, saw);
    checks++;
    if (cnt != 16 || saw !== 1'b0) begin
      failures++;
      $display("FAIL collide_sweep busy_cycles=%0d saw_vld=%b required 16 and 0", cnt, saw);
    end
    rd1(4'd5, d, v);
    checks++;
    if (d !== 8'h00 || v !== 1'b1) begin
      failures++;
      $display("FAIL collide_read dout=%h vld=%b required 00 1", d, v);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt; logic saw; logic [7:0] d; logic v;
    for (int i = 0; i < 16; i++) wr1(4'(i), 8'hA0 | 8'(i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || dout !== 8'h00 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_values busy=%b dout=%h vld=%b required 1 00 0", busy, dout, dout_valid);
    end
    rst = 1'b0;
    wait_sweep1(cnt, saw);
    checks++;
    if (cnt != 16 || saw !== 1'b0) begin
      failures++;
      $display("FAIL midrst_sweep busy_cycles=%0d saw_vld=%b required 16 and 0", cnt, saw);
    end
    for (int i = 0; i < 16; i++) begin
      rd1(4'(i), d, v);
      checks++;
      if (d !== 8'h00 || v !== 1'b1) begin
        failures++;
        $display("FAIL midrst_read addr=%0d dout=%h vld=%b required 00 1", i, d, v);
      end
    end
  endtask

  task automatic test_wide();
    int cnt; int lat; logic [15:0] d;
    rst2 = 1'b0;
    cnt = 0;
    while (busy2 === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL wide_sweep busy_cycles=%0d required 64", cnt);
    end
    // Clear value check at both ends of the array.
    for (int k = 0; k < 2; k++) begin
      en2 = 1'b1; we2 = 1'b0; addr2 = (k == 0) ? 6'd0 : 6'd63;
      tick();
      en2 = 1'b0;
      for (int i = 1; i < LAT; i++) tick();
      checks++;
      if (dout2 !== 16'hA5A5 || dout_valid2 !== 1'b1) begin
        failures++;
        $display("FAIL wide_clear addr=%0d dout=%h vld=%b required a5a5 1", addr2, dout2, dout_valid2);
      end
    end
    en2 = 1'b1; we2 = 1'b1; addr2 = 6'd63; din2 = 16'hBEEF;
    tick();
    we2 = 1'b0; addr2 = 6'd63;
    tick();
    en2 = 1'b0;
    lat = 0; d = '0;
    for (int k = 1; k <= 4; k++) begin
      if (dout_valid2 === 1'b1 && lat == 0) begin
        lat = k; d = dout2;
      end
      tick();
    end
    checks++;
    if (lat != LAT || d !== 16'hBEEF) begin
      failures++;
      $display("FAIL wide_read latency=%0d dout=%h required %0d beef", lat, d, LAT);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; din = '0;
    rst2 = 1'b1; en2 = 1'b0; we2 = 1'b0; clr2 = 1'b0; addr2 = '0; din2 = '0;
    test_reset();
    test_write_readback();
    test_busy_drop();
    test_clr_collision();
    test_reset_mid_sweep();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
